lsu_stage: RTL and testbench

Parametrised load/store unit for the RV32I MEM stage, between the EX/MEM boundary and the data memory. Adds a request/grant/response handshake with variable latency, a pipeline stall, byte-lane write strobes, correct sub-word sign extension, a selectable data-bus width and misaligned-access detection. Results go out through a registered MEM pipeline register tagged with a valid bit.

---
 rtl/RV32I_definitions.sv | 19 +
 rtl/mem_lane_align.sv | 61 ++++++
 rtl/lsu_stage.sv | 212 +++++++++++++++++++++
 tb/tb_lsu_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/RV32I_definitions.sv
// RV32I shared definitions: memory op codes (funct3 encoding) and the LSU FSM state type.
package RV32I_definitions;

    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b100;
    localparam logic [2:0] MEM_LHU = 3'b101;
    localparam logic [2:0] MEM_SB  = 3'b000;
    localparam logic [2:0] MEM_SH  = 3'b001;
    localparam logic [2:0] MEM_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the LSU: store strobes/replicated data, misalignment
// detection on the incoming op, and extraction/extension of returned load data.
module mem_lane_align
    import RV32I_definitions::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]                     st_op_i,
    input  logic [$clog2(DATA_W/8)-1:0]    st_off_i,
    input  logic [31:0]                    st_data_i,
    output logic [DATA_W/8-1:0]            be_o,
    output logic [DATA_W-1:0]              wdata_o,
    output logic                           misaligned_o,
    input  logic [2:0]                     ld_op_i,
    input  logic [$clog2(DATA_W/8)-1:0]    ld_off_i,
    input  logic [DATA_W-1:0]              rdata_i,
    output logic [31:0]                    dout_o
);

    localparam int unsigned NB = DATA_W / 8;

    logic [31:0] word;

    // Store side; load and store op codes share the size encoding in bits [1:0].
    always_comb begin
        be_o         = '0;
        wdata_o      = '0;
        misaligned_o = 1'b0;
        case (st_op_i)
            MEM_LB, MEM_LBU: begin
                be_o    = NB'(1) << st_off_i;
                wdata_o = {NB{st_data_i[7:0]}};
            end
            MEM_LH, MEM_LHU: begin
                be_o         = NB'(2'b11) << st_off_i;
                wdata_o      = {(NB/2){st_data_i[15:0]}};
                misaligned_o = st_off_i[0];
            end
            MEM_LW: begin
                be_o         = NB'(4'hF) << st_off_i;
                wdata_o      = {(NB/4){st_data_i}};
                misaligned_o = (st_off_i[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    // Load side: bring the addressed byte lane down to bit 0, then extend.
    always_comb begin
        word   = 32'(rdata_i >> {ld_off_i, 3'b000});
        dout_o = word;
        case (ld_op_i)
            MEM_LB:  dout_o = {{24{word[7]}}, word[7:0]};
            MEM_LH:  dout_o = {{16{word[15]}}, word[15:0]};
            MEM_LBU: dout_o = {24'h0, word[7:0]};
            MEM_LHU: dout_o = {16'h0, word[15:0]};
            default: dout_o = word;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// RV32I MEM-stage load/store unit: req/gnt/rvalid data-memory handshake with
// pipeline stall, misalignment trap and a valid-tagged MEM pipeline register.
module lsu_stage
    import RV32I_definitions::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    EX_valid,
    input  logic                    EX_Mem_wr_en,
    input  logic                    EX_Mem_rd_en,
    input  logic [2:0]              EX_Mem_op,
    input  logic                    EX_MemToReg,
    input  logic                    EX_RegFile_wr_en,
    input  logic [ADDR_W-1:0]       EX_ALU_result,
    input  logic [31:0]             EX_Rs2_data,
    input  logic [4:0]              EX_Rd_addr,
    output logic                    MEM_stall,
    output logic                    MEM_valid,
    output logic [31:0]             MEM_dout,
    output logic                    MEM_MemToReg,
    output logic                    MEM_RegFile_wr_en,
    output logic [ADDR_W-1:0]       MEM_ALU_result,
    output logic [4:0]              MEM_Rd_addr,
    output logic                    MEM_misaligned,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [ADDR_W-1:0]       dmem_addr,
    output logic [DATA_W/8-1:0]     dmem_be,
    output logic [DATA_W-1:0]       dmem_wdata,
    input  logic                    dmem_gnt,
    input  logic                    dmem_rvalid,
    input  logic [DATA_W-1:0]       dmem_rdata
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned LB = $clog2(NB);

    lsu_state_t          state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [LB-1:0]       lane_q, lane_d;
    logic                m2r_q, m2r_d, rfwe_q, rfwe_d;
    logic [4:0]          rd_q, rd_d;
    logic [ADDR_W-1:0]   alu_q, alu_d;
    logic                req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NB-1:0]       be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                mvalid_q, mvalid_d, mmis_q, mmis_d, mm2r_q, mm2r_d, mrfwe_q, mrfwe_d;
    logic [31:0]         mdout_q, mdout_d;
    logic [ADDR_W-1:0]   malu_q, malu_d;
    logic [4:0]          mrd_q, mrd_d;

    logic                ex_is_mem, ex_mis;
    logic [NB-1:0]       ex_be;
    logic [DATA_W-1:0]   ex_wdata;
    logic [31:0]         ld_dout;

    assign ex_is_mem = EX_Mem_wr_en | EX_Mem_rd_en;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .st_op_i      (EX_Mem_op),
        .st_off_i     (EX_ALU_result[LB-1:0]),
        .st_data_i    (EX_Rs2_data),
        .be_o         (ex_be),
        .wdata_o      (ex_wdata),
        .misaligned_o (ex_mis),
        .ld_op_i      (op_q),
        .ld_off_i     (lane_q),
        .rdata_i      (dmem_rdata),
        .dout_o       (ld_dout)
    );

    // Next state; the MEM register defaults to a bubble every cycle.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        lane_d   = lane_q;
        m2r_d    = m2r_q;
        rfwe_d   = rfwe_q;
        rd_d     = rd_q;
        alu_d    = alu_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        mvalid_d = 1'b0;
        mmis_d   = 1'b0;
        mm2r_d   = mm2r_q;
        mrfwe_d  = mrfwe_q;
        mdout_d  = mdout_q;
        malu_d   = malu_q;
        mrd_d    = mrd_q;
        case (state_q)
            IDLE: begin
                if (EX_valid && ex_is_mem && !ex_mis) begin
                    state_d = REQ;
                    op_d    = EX_Mem_op;
                    lane_d  = EX_ALU_result[LB-1:0];
                    m2r_d   = EX_MemToReg;
                    rfwe_d  = EX_RegFile_wr_en;
                    rd_d    = EX_Rd_addr;
                    alu_d   = EX_ALU_result;
                    req_d   = 1'b1;
                    we_d    = EX_Mem_wr_en;
                    addr_d  = EX_ALU_result & ~ADDR_W'(NB - 1);
                    be_d    = ex_be;
                    wdata_d = ex_wdata;
                end else if (EX_valid) begin
                    // Non-memory op passes straight through; a misaligned one retires as a trap.
                    mvalid_d = 1'b1;
                    mmis_d   = ex_is_mem;
                    mm2r_d   = EX_MemToReg;
                    mrfwe_d  = EX_RegFile_wr_en & ~ex_is_mem;
                    mdout_d  = '0;
                    malu_d   = EX_ALU_result;
                    mrd_d    = EX_Rd_addr;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d  = IDLE;
                        mvalid_d = 1'b1;
                        mm2r_d   = m2r_q;
                        mrfwe_d  = rfwe_q;
                        mdout_d  = '0;
                        malu_d   = alu_q;
                        mrd_d    = rd_q;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    state_d  = IDLE;
                    mvalid_d = 1'b1;
                    mm2r_d   = m2r_q;
                    mrfwe_d  = rfwe_q;
                    mdout_d  = ld_dout;
                    malu_d   = alu_q;
                    mrd_d    = rd_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            lane_q   <= '0;
            m2r_q    <= 1'b0;
            rfwe_q   <= 1'b0;
            rd_q     <= '0;
            alu_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            mvalid_q <= 1'b0;
            mmis_q   <= 1'b0;
            mm2r_q   <= 1'b0;
            mrfwe_q  <= 1'b0;
            mdout_q  <= '0;
            malu_q   <= '0;
            mrd_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            lane_q   <= lane_d;
            m2r_q    <= m2r_d;
            rfwe_q   <= rfwe_d;
            rd_q     <= rd_d;
            alu_q    <= alu_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            mvalid_q <= mvalid_d;
            mmis_q   <= mmis_d;
            mm2r_q   <= mm2r_d;
            mrfwe_q  <= mrfwe_d;
            mdout_q  <= mdout_d;
            malu_q   <= malu_d;
            mrd_q    <= mrd_d;
        end
    end

    assign MEM_stall         = (state_q != IDLE);
    assign MEM_valid         = mvalid_q;
    assign MEM_dout          = mdout_q;
    assign MEM_MemToReg      = mm2r_q;
    assign MEM_RegFile_wr_en = mrfwe_q;
    assign MEM_ALU_result    = malu_q;
    assign MEM_Rd_addr       = mrd_q;
    assign MEM_misaligned    = mmis_q;
    assign dmem_req          = req_q;
    assign dmem_we           = we_q;
    assign dmem_addr         = addr_q;
    assign dmem_be           = be_q;
    assign dmem_wdata        = wdata_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: a 32-bit instance for the handshake, sub-word and
// trap cases, and a 64-bit instance for wide-bus lane selection.
module tb_lsu_stage;
    import RV32I_definitions::*;

    logic clk, rst;
    int   total = 0;
    int   bad   = 0;

    // 32-bit instance signals
    logic        ex_valid, ex_wr, ex_rd, ex_m2r, ex_rfwe;
    logic [2:0]  ex_op;
    logic [31:0] ex_alu, ex_rs2;
    logic [4:0]  ex_rdaddr;
    logic        m_stall, m_valid, m_m2r, m_rfwe, m_mis;
    logic [31:0] m_dout, m_alu;
    logic [4:0]  m_rd;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;

    // 64-bit instance signals
    logic        x_valid, x_wr, x_rd, x_m2r, x_rfwe;
    logic [2:0]  x_op;
    logic [31:0] x_alu, x_rs2;
    logic [4:0]  x_rdaddr;
    logic        y_stall, y_valid, y_m2r, y_rfwe, y_mis;
    logic [31:0] y_dout, y_alu;
    logic [4:0]  y_rd;
    logic        w_req, w_we, w_gnt, w_rvalid;
    logic [31:0] w_addr;
    logic [63:0] w_wdata, w_rdata;
    logic [7:0]  w_be;

    lsu_stage #(.DATA_W(32), .ADDR_W(32)) dut32 (
        .Clk(clk), .Reset(rst), .EX_valid(ex_valid), .EX_Mem_wr_en(ex_wr), .EX_Mem_rd_en(ex_rd),
        .EX_Mem_op(ex_op), .EX_MemToReg(ex_m2r), .EX_RegFile_wr_en(ex_rfwe), .EX_ALU_result(ex_alu),
        .EX_Rs2_data(ex_rs2), .EX_Rd_addr(ex_rdaddr), .MEM_stall(m_stall), .MEM_valid(m_valid),
        .MEM_dout(m_dout), .MEM_MemToReg(m_m2r), .MEM_RegFile_wr_en(m_rfwe), .MEM_ALU_result(m_alu),
        .MEM_Rd_addr(m_rd), .MEM_misaligned(m_mis), .dmem_req(d_req), .dmem_we(d_we),
        .dmem_addr(d_addr), .dmem_be(d_be), .dmem_wdata(d_wdata), .dmem_gnt(d_gnt),
        .dmem_rvalid(d_rvalid), .dmem_rdata(d_rdata)
    );

    lsu_stage #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .Clk(clk), .Reset(rst), .EX_valid(x_valid), .EX_Mem_wr_en(x_wr), .EX_Mem_rd_en(x_rd),
        .EX_Mem_op(x_op), .EX_MemToReg(x_m2r), .EX_RegFile_wr_en(x_rfwe), .EX_ALU_result(x_alu),
        .EX_Rs2_data(x_rs2), .EX_Rd_addr(x_rdaddr), .MEM_stall(y_stall), .MEM_valid(y_valid),
        .MEM_dout(y_dout), .MEM_MemToReg(y_m2r), .MEM_RegFile_wr_en(y_rfwe), .MEM_ALU_result(y_alu),
        .MEM_Rd_addr(y_rd), .MEM_misaligned(y_mis), .dmem_req(w_req), .dmem_we(w_we),
        .dmem_addr(w_addr), .dmem_be(w_be), .dmem_wdata(w_wdata), .dmem_gnt(w_gnt),
        .dmem_rvalid(w_rvalid), .dmem_rdata(w_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One memory op on the 32-bit instance; returns right after the MEM register loads.
    task automatic txn(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [4:0] rd, input logic rfwe,
                       input int gwait, input int rwait, input logic [31:0] rdata,
                       input logic [3:0] ebe, input logic [31:0] ewd);
        ex_valid = 1'b1; ex_wr = wr; ex_rd = ~wr; ex_op = op; ex_alu = addr;
        ex_rs2 = rs2; ex_rdaddr = rd; ex_rfwe = rfwe; ex_m2r = ~wr;
        step();
        ex_valid = 1'b0;
        chk("req_first", {m_stall, d_req, m_valid, d_we}, {1'b1, 1'b1, 1'b0, wr});
        chk("req_addr", d_addr, addr & ~32'h3);
        chk("req_be", d_be, ebe);
        chk("req_wdata", d_wdata, ewd);
        for (int i = 0; i < gwait; i++) begin
            step();
            chk("req_held", {m_stall, d_req, m_valid, d_be, d_addr}, {1'b1, 1'b1, 1'b0, ebe, addr & ~32'h3});
        end
        d_gnt = 1'b1; d_rvalid = 1'b1; d_rdata = 32'hDEADBEEF;
        step();
        d_gnt = 1'b0; d_rvalid = 1'b0;
        if (!wr) begin
            chk("resp_wait", {m_stall, d_req, m_valid}, 3'b100);
            for (int i = 0; i < rwait; i++) begin
                step();
                chk("resp_wait", {m_stall, d_req, m_valid}, 3'b100);
            end
            d_rvalid = 1'b1; d_rdata = rdata;
            step();
            d_rvalid = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 0; ex_wr = 0; ex_rd = 0; ex_op = '0; ex_m2r = 0; ex_rfwe = 0;
        ex_alu = '0; ex_rs2 = '0; ex_rdaddr = '0; d_gnt = 0; d_rvalid = 0; d_rdata = '0;
        x_valid = 0; x_wr = 0; x_rd = 0; x_op = '0; x_m2r = 0; x_rfwe = 0;
        x_alu = '0; x_rs2 = '0; x_rdaddr = '0; w_gnt = 0; w_rvalid = 0; w_rdata = '0;
        step();
        step();
        chk("rst_ctrl32", {m_stall, m_valid, m_mis, m_rfwe, d_req, d_we, d_be}, '0);
        chk("rst_data32", {m_dout, m_alu}, '0);
        chk("rst_ctrl64", {y_stall, y_valid, y_mis, w_req, w_we, w_be}, '0);
        rst = 1'b0;
        step();

        // SB 0x1003: top lane, byte replicated, retires two edges after acceptance
        txn(1'b1, MEM_SB, 32'h1003, 32'hAABBCCDD, 5'd0, 1'b0, 0, 0, '0, 4'b1000, 32'hDDDDDDDD);
        chk("sb_retire", {m_valid, m_stall, d_req, m_mis}, 4'b1000);
        chk("sb_alu", m_alu, 32'h1003);
        step();
        chk("sb_bubble", {m_valid, m_stall}, 2'b00);

        // SH 0x1002: upper halfword lanes
        txn(1'b1, MEM_SH, 32'h1002, 32'h1234ABCD, 5'd0, 1'b0, 1, 0, '0, 4'b1100, 32'hABCDABCD);
        chk("sh_retire", m_valid, 1'b1);

        // LB / LBU / LH sub-word extraction
        txn(1'b0, MEM_LB, 32'h2001, '0, 5'd3, 1'b1, 0, 0, 32'h00008000, 4'b0010, '0);
        chk("lb_valid", {m_valid, m_rfwe, m_m2r, m_rd}, {3'b111, 5'd3});
        chk("lb_dout", m_dout, 32'hFFFFFF80);
        txn(1'b0, MEM_LBU, 32'h2001, '0, 5'd0, 1'b1, 0, 1, 32'h00008000, 4'b0010, '0);
        chk("lbu_dout", m_dout, 32'h00000080);
        chk("lbu_rd0", {m_valid, m_rfwe, m_rd}, {2'b11, 5'd0});
        txn(1'b0, MEM_LH, 32'h2002, '0, 5'd4, 1'b1, 0, 0, 32'h80010000, 4'b1100, '0);
        chk("lh_dout", m_dout, 32'hFFFF8001);

        // LW with slow grant and response, then an ADD retires exactly once
        txn(1'b0, MEM_LW, 32'h2004, '0, 5'd5, 1'b1, 3, 2, 32'hCAFEF00D, 4'b1111, '0);
        chk("lw_dout", {m_valid, m_stall, m_dout}, {2'b10, 32'hCAFEF00D});
        ex_valid = 1'b1; ex_wr = 0; ex_rd = 0; ex_alu = 32'h55; ex_rdaddr = 5'd7; ex_rfwe = 1; ex_m2r = 0;
        step();
        ex_valid = 1'b0;
        chk("add_retire", {m_valid, m_stall, d_req, m_rfwe, m_rd}, {4'b1001, 5'd7});
        chk("add_alu", {m_alu, m_dout}, {32'h55, 32'h0});
        step();
        chk("add_once", {m_valid, d_req}, 2'b00);

        // Misaligned SW and LHU trap without a bus request
        ex_valid = 1'b1; ex_wr = 1; ex_rd = 0; ex_op = MEM_SW; ex_alu = 32'h3002; ex_rfwe = 1; ex_rdaddr = 5'd9;
        step();
        chk("sw_mis", {m_mis, m_valid, m_rfwe, d_req, m_stall}, 5'b11000);
        ex_wr = 0; ex_rd = 1; ex_op = MEM_LHU; ex_alu = 32'h2003;
        step();
        ex_valid = 1'b0;
        chk("lhu_mis", {m_mis, m_valid, m_rfwe, d_req, m_stall}, 5'b11000);
        step();
        chk("mis_clear", {m_mis, m_valid, d_req}, 3'b000);

        // Reset while waiting for the response; a late rvalid must be ignored
        ex_valid = 1'b1; ex_wr = 0; ex_rd = 1; ex_op = MEM_LW; ex_alu = 32'h2008; ex_rdaddr = 5'd6;
        step();
        ex_valid = 1'b0;
        d_gnt = 1'b1;
        step();
        d_gnt = 1'b0;
        chk("pre_rst_resp", {m_stall, d_req}, 2'b10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_in_resp", {m_stall, m_valid, d_req, d_we, d_be, m_rfwe}, '0);
        chk("rst_in_resp_data", {m_dout, m_alu}, '0);
        d_rvalid = 1'b1; d_rdata = 32'h11111111;
        step();
        d_rvalid = 1'b0;
        chk("late_rvalid", {m_stall, m_valid, m_dout}, '0);

        // 64-bit bus: LW in the upper word, then the matching SW strobes
        x_valid = 1'b1; x_wr = 0; x_rd = 1; x_op = MEM_LW; x_alu = 32'h4004; x_rdaddr = 5'd8; x_rfwe = 1;
        step();
        x_valid = 1'b0;
        chk("w_lw_req", {w_req, w_we, w_be, w_addr}, {2'b10, 8'hF0, 32'h4000});
        w_gnt = 1'b1;
        step();
        w_gnt = 1'b0;
        w_rvalid = 1'b1; w_rdata = 64'h12345678_9ABCDEF0;
        step();
        w_rvalid = 1'b0;
        chk("w_lw_dout", {y_valid, y_dout}, {1'b1, 32'h12345678});
        x_valid = 1'b1; x_wr = 1; x_rd = 0; x_op = MEM_SW; x_rs2 = 32'h11223344;
        step();
        x_valid = 1'b0;
        chk("w_sw_be", {w_req, w_we, w_be}, {2'b11, 8'hF0});
        chk("w_sw_wdata", w_wdata, 64'h11223344_11223344);
        w_gnt = 1'b1;
        step();
        w_gnt = 1'b0;
        chk("w_sw_retire", {y_valid, y_stall, w_req}, 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
